// File: rtl/lfsr_stream_decrypt_pkg.sv
// rtl/lfsr_stream_decrypt_pkg.sv - shared LFSR cipher constants, state codes and step function
package lfsr_stream_decrypt_pkg;

    localparam int          LFSR_W_DEF   = 16;
    localparam int          DATA_W_DEF   = 8;
    localparam int          LFSR_MAX_W   = 32;
    localparam logic [15:0] TAPS_DEF     = 16'hB400;
    localparam logic [15:0] ZERO_SUB_DEF = 16'hACE1;

    typedef logic [1:0] state_t;

    localparam state_t ST_UNSEEDED = 2'd0;
    localparam state_t ST_GEN      = 2'd1;
    localparam state_t ST_WAIT_IN  = 2'd2;
    localparam state_t ST_OUT      = 2'd3;

    // Operands are zero-extended to LFSR_MAX_W so any width up to 32 shares this one definition.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (cur >> 1) ^ (cur[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - Galois LFSR register with seed load, step enable and bit output
module lfsr_galois
    import lfsr_stream_decrypt_pkg::*;
#(
    parameter int           W        = LFSR_W_DEF,
    parameter logic [W-1:0] TAPS     = TAPS_DEF,
    parameter logic [W-1:0] ZERO_SUB = ZERO_SUB_DEF
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         step,
    output logic         bit_out
);

    logic [W-1:0] lfsr;

    // An all-zero state would lock up, so a zero seed is replaced by ZERO_SUB.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= (load_value == '0) ? ZERO_SUB : load_value;
        end else if (step) begin
            lfsr <= W'(lfsr_step(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS)));
        end
    end

    assign bit_out = lfsr[0];

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// rtl/lfsr_stream_decrypt.sv - byte-serial LFSR stream decryptor with valid/ready ports
module lfsr_stream_decrypt
    import lfsr_stream_decrypt_pkg::*;
#(
    parameter int                LFSR_W   = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS     = TAPS_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [LFSR_W-1:0] ZERO_SUB = ZERO_SUB_DEF
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] key;
    logic              lfsr_bit;
    logic              lfsr_step_en;

    assign lfsr_step_en = (state == ST_GEN) && !seed_load;
    assign busy         = (state == ST_GEN);

    lfsr_galois #(
        .W        (LFSR_W),
        .TAPS     (TAPS),
        .ZERO_SUB (ZERO_SUB)
    ) u_lfsr (
        .clk        (clk),
        .clear_n    (clear_n),
        .load       (seed_load),
        .load_value (seed),
        .step       (lfsr_step_en),
        .bit_out    (lfsr_bit)
    );

    // in_ready and out_valid are flops set alongside the state transition, never decoded.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_UNSEEDED;
            bit_cnt   <= '0;
            key       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (seed_load) begin
            state     <= ST_GEN;
            bit_cnt   <= '0;
            key       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_GEN: begin
                    key     <= {key[DATA_W-2:0], lfsr_bit};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state    <= ST_WAIT_IN;
                        in_ready <= 1'b1;
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        out_data  <= in_data ^ key;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= ST_GEN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// tb/tb_lfsr_stream_decrypt.sv - scoreboard bench for lfsr_stream_decrypt
module tb_lfsr_stream_decrypt;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 1;
    int          n_out = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    lfsr_stream_decrypt dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference keystream: eight Galois shifts of the x^16+x^14+x^13+x^11+1 register, first bit -> MSB.
    function automatic logic [23:0] ks_byte(input logic [15:0] s);
        logic [15:0] v;
        int          k;
        v = s;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            k = k * 2 + int'(v % 2);
            v = (v % 2 == 1) ? ((v / 2) ^ 16'hB400) : (v / 2);
        end
        return {v, k[7:0]};
    endfunction

    task automatic enc(input logic [7:0] p, output logic [7:0] c);
        logic [23:0] r;
        r      = ks_byte(m_lfsr);
        m_lfsr = r[23:8];
        c      = p ^ r[7:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed      = s;
        seed_load = 1'b1;
        exp_q.delete();
        m_lfsr    = (s == 16'h0) ? 16'hACE1 : s;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] p, input int gap);
        bit ok;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = c;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back(p);
                break;
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end else begin
            @(negedge clk);
            chk("out_valid_latency", 32'(out_valid), 32'd1);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain", {31'(exp_q.size()), out_valid}, 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a handshake happens on the coming edge unless a seed load overrides it.
    initial begin
        forever begin
            @(negedge clk);
            if (clear_n && out_valid && out_ready && !seed_load) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h expected=none", out_data);
                end else begin
                    chk("plaintext", 32'(out_data), 32'(exp_q.pop_front()));
                    n_out++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  p, c, od;
        logic [15:0] ls;
        int          base;

        clear_n   = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0;
        in_valid  = 1'b0;
        in_data   = 8'h0;
        m_lfsr    = 16'h0;
        @(negedge clk);
        chk("reset_outputs", {28'h0, in_ready, out_valid, busy, 1'b0}, 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_lfsr", 32'(dut.u_lfsr.lfsr), 32'd0);
        tick();
        clear_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) begin
            @(negedge clk);
            chk("unseeded_in_ready", {30'h0, in_ready, busy}, 32'd0);
        end
        tick();
        in_valid = 1'b0;

        // Basic decrypt and seed-to-ready timing
        do_seed(16'hACE1);
        repeat (8) begin
            @(negedge clk);
            chk("gen_busy", {30'h0, busy, in_ready}, 32'b10);
        end
        @(negedge clk);
        chk("gen_done_ready", {30'h0, busy, in_ready}, 32'b01);
        chk("lfsr_after_byte", 32'(dut.u_lfsr.lfsr), 32'hC2C4);
        tick();
        enc(8'h0, c);
        send(8'h00, 8'h87, 0);
        drain();
        do_seed(16'hACE1);
        enc(8'h0, c);
        send(8'h41, 8'hC6, 0);
        drain();

        // Zero seed substitutes ZERO_SUB
        do_seed(16'h0000);
        enc(8'h0, c);
        send(8'h00, 8'h87, 0);
        drain();

        // Backpressure
        do_seed(16'h1D2B);
        ready_mode = 0;
        tick();
        p = 8'($urandom);
        enc(p, c);
        send(c, p, 0);
        od = out_data;
        ls = dut.u_lfsr.lfsr;
        repeat (20) begin
            @(negedge clk);
            chk("bp_out_data", 32'(out_data), 32'(od));
            chk("bp_flags", {30'h0, out_valid, in_ready}, 32'b10);
            chk("bp_lfsr", 32'(dut.u_lfsr.lfsr), 32'(ls));
        end
        tick();
        ready_mode = 1;
        drain();
        p = 8'($urandom);
        enc(p, c);
        send(c, p, 0);
        drain();

        // Round trip with random gaps and random consumer stalls
        do_seed(16'($urandom));
        ready_mode = 2;
        base = n_out;
        for (int i = 0; i < 256; i++) begin
            p = 8'($urandom);
            enc(p, c);
            send(c, p, $urandom_range(0, 3));
        end
        ready_mode = 1;
        drain();
        chk("round_trip_count", 32'(n_out - base), 32'd256);

        // Reseed while an output handshake is pending
        do_seed(16'h1234);
        ready_mode = 0;
        tick();
        p = 8'($urandom);
        enc(p, c);
        send(c, p, 0);
        ready_mode = 1;
        tick();
        seed      = 16'hACE1;
        seed_load = 1'b1;
        exp_q.delete();
        m_lfsr    = 16'hACE1;
        @(negedge clk);
        chk("reseed_precond", {30'h0, out_valid, out_ready}, 32'b11);
        @(posedge clk);
        #2;
        seed_load = 1'b0;
        @(negedge clk);
        chk("reseed_drop", {30'h0, out_valid, busy}, 32'b01);
        tick();
        enc(8'h0, c);
        send(8'h00, 8'h87, 0);
        drain();

        // Asynchronous reset in the middle of GEN
        do_seed(16'hACE1);
        tick();
        tick();
        #1;
        clear_n = 1'b0;
        #1;
        chk("async_flags", {29'h0, in_ready, out_valid, busy}, 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        chk("async_lfsr", 32'(dut.u_lfsr.lfsr), 32'd0);
        @(posedge clk);
        #2;
        clear_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (20) begin
            @(negedge clk);
            chk("post_reset_idle", {30'h0, in_ready, busy}, 32'd0);
        end
        tick();
        in_valid = 1'b0;
        do_seed(16'hACE1);
        enc(8'h0, c);
        send(8'h00, 8'h87, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_decrypt.md
# lfsr_stream_decrypt

Byte-serial stream-cipher decryptor: the receive-side counterpart of the team's LFSR stream encryptor. It regenerates the keystream from a shared 16-bit seed using a Galois LFSR, one keystream bit per clock. It XORs each ciphertext byte with the next keystream byte and returns plaintext over a valid/ready interface. It sits between the ciphertext ingress path and the plaintext consumer.

## Interface
- `LFSR_W`, default 16: LFSR width.
- `TAPS`, default 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- `DATA_W`, default 8: byte width, which is also the number of LFSR steps per byte.
- `ZERO_SUB`, default 16'hACE1: value loaded in place of an all-zero seed.
- `clk`  in  1: single clock, rising edge.
- `clear_n`  in  1: reset, asynchronous, active-low.
- `seed_load`  in  1: one-cycle strobe; loads `seed` and restarts the keystream.
- `seed`  in  LFSR_W: shared key/seed.
- `in_valid`  in  1: ciphertext byte valid.
- `in_ready`  out  1: decryptor can accept a ciphertext byte.
- `in_data`  in  DATA_W: ciphertext byte.
- `out_valid`  out  1: plaintext byte valid.
- `out_ready`  in  1: consumer accepts the plaintext byte.
- `out_data`  out  DATA_W: plaintext byte.
- `busy`  out  1: keystream byte generation in progress.

## Operation
- **FSM states:** UNSEEDED, GEN, WAIT_IN, OUT.
- **UNSEEDED:** reset state. `in_ready`=0. Any `in_valid` is ignored.
- **seed_load (any state):** `lfsr` <= (`seed`==0 ? ZERO_SUB : `seed`). `key` <= 0, `bit_cnt` <= 0, `out_valid` <= 0, and the state goes to GEN. Any pending output byte is discarded. This load has priority over every other event in the same cycle, including a handshake.
- **LFSR step in GEN:** b = `lfsr`[0]; `lfsr` <= (`lfsr`>>1) ^ (b ? TAPS : 0); `key` <= {`key`[DATA_W-2:0], b}. The first bit generated ends up as the MSB of `key`.
- **GEN duration:** exactly DATA_W steps. After the last step the state goes to WAIT_IN.
- **WAIT_IN:** `in_ready`=1. On `in_valid`&&`in_ready`: `out_data` <= `in_data` ^ `key`, `out_valid` <= 1, and the state goes to OUT.
- **OUT:** `out_valid`=1, with `out_data` held stable until `out_ready`. On `out_valid`&&`out_ready`: `out_valid` <= 0, `bit_cnt` <= 0, and the state goes to GEN for the next byte. The LFSR continues from its current state and is never reseeded implicitly.
- **Backpressure:** `in_ready`=0 in GEN, OUT and UNSEEDED. There is no input buffering.
- **busy:** equals (state==GEN).
- **Keystream alignment:** identical to the encryptor's when both ends use the same seed and process the same byte sequence.

## Timing
- **Reset values:** state=UNSEEDED, `lfsr`=0, `key`=0, `bit_cnt`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- **Seed to ready:** `seed_load` sampled at edge 0. GEN runs during cycles 1..DATA_W. `in_ready`=1 from cycle DATA_W+1.
- **Input to output:** input accepted at edge k gives `out_valid`=1 from cycle k+1. Combinational paths from input to output are forbidden.
- **Output to ready:** output accepted at edge m gives GEN from m+1 and `in_ready` again at m+DATA_W+1.
- **Throughput:** minimum DATA_W+2 cycles per byte with `out_ready` tied high.
- **Reset mid-operation:** asserting `clear_n`=0 returns all outputs to reset values immediately. The module then stays in UNSEEDED until `seed_load`.
- **Ready/valid outputs:** `in_ready` and `out_valid` are registered and glitch-free. `out_data` only changes on an input handshake, a seed load or reset.

## Structure
- **Shared package:** state enum, default `TAPS`, `ZERO_SUB`, and the LFSR step function, so the encryptor and decryptor share one definition.
- **Sub-module:** one natural sub-module, `lfsr_galois`, containing the LFSR register with load/step enables and the bit output. The encryptor reuses it.
- **Top level:** the FSM, `bit_cnt`, the key shift register and the output register.

## Test plan
- **Basic decrypt:** reset, `seed_load` with 16'hACE1. Expect `busy` for 8 cycles and `in_ready` in cycle 9. Send `in_data`=8'h00 → `out_data`=8'h87, LFSR=16'hC2C4. Repeat with `in_data`=8'h41 → 8'hC6.
- **Zero seed:** `seed`=0 → behaviour identical to `seed`=16'hACE1, giving first plaintext 8'h87 for ciphertext 8'h00.
- **Backpressure:** hold `out_ready`=0 for 20 cycles. Expect `out_data` stable, `in_ready`=0 and the LFSR frozen. Release `out_ready` → next keystream byte matches the golden encryptor model.
- **Round trip:** feed 256 bytes from the encryptor (same seed) with random `in_valid`/`out_ready` gaps. Plaintext must equal the original bytes in order, with no drops or duplicates.
- **Reseed in OUT:** `seed_load` while `out_valid`=1 and `out_ready`=1 in the same cycle. Expect the handshake ignored, `out_valid`=0 the next cycle, and the keystream restarted, so the first byte again gives 8'h87 for 8'h00.
- **Async reset:** assert `clear_n` low mid-GEN between clock edges. Outputs go to reset values immediately, and `in_valid` is ignored until a new `seed_load`.
